rand_req_arbiter: RTL and testbench
===================================

Name: rand_req_arbiter

Overview:
- Shares the free-running game random source (8-bit values, 0..23 sequence) between several requesters, e.g. ball, CPU players and kick-off logic.
- Round-robin arbitration picks one requester at a time.
- The block samples the source, reduces the value modulo the requester's bound by iterative subtraction, and can optionally reject an immediate repeat of that requester's previous value.
- It returns the result with a one-cycle ack.

Parameters:
- N_REQ, 4, number of requesters.
- DATA_W, 8, width of the random value, bound and result.
- MAX_RETRY, 3, maximum resamples when a no-repeat conflict occurs.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rand_in  in  DATA_W  current value from the random source.
- req  in  N_REQ  level request per requester.
- bound  in  N_REQ*DATA_W  per-requester modulus. Slice i is bits [i*DATA_W +: DATA_W]. Value 0 means no reduction.
- no_repeat  in  N_REQ  per-requester repeat-rejection enable.
- ack  out  N_REQ  one-hot, one-cycle completion pulse.
- rand_out  out  DATA_W  result, valid while ack is high and held afterwards.
- busy  out  1  high from grant until the DONE cycle ends.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, ack=0, rand_out=0, busy=0.
  - Round-robin pointer=0.
  - All last_val=0 and all last_valid=0.
  - retry=0.
- All outputs are registered.
- FSM states: IDLE, SAMPLE, REDUCE, CHECK, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from the pointer, wrapping at N_REQ.
  - Latch grant index g, bound[g] and no_repeat[g]. Set retry=0 and busy=1.
  - Set pointer=(g+1) mod N_REQ. Go to SAMPLE.
  - If no req bit is set, stay in IDLE.
- SAMPLE: work <= rand_in. Go to REDUCE.
- REDUCE:
  - If the latched bound is 0, or work < bound, go to CHECK.
  - Otherwise work <= work - bound and stay in REDUCE. This is one subtraction per cycle, unsigned DATA_W arithmetic, with no underflow possible.
- CHECK:
  - If no_repeat is latched, last_valid[g]=1, work==last_val[g] and retry<MAX_RETRY: increment retry and go to SAMPLE.
  - Otherwise go to DONE.
- DONE:
  - ack[g]=1 and rand_out=work, both registered on entry.
  - last_val[g] <= work, last_valid[g] <= 1, busy falls at the end of the cycle.
  - Go unconditionally to IDLE.
- Latency, measured from the first IDLE cycle with req high (block idle) to the ack cycle:
  - 4 cycles with no subtractions and no retries.
  - Add 1 cycle per subtraction.
  - Add 3 cycles plus that pass's subtractions for each retry.
- Handshake:
  - req is level-sensitive.
  - A requester must drop req at the edge where it samples ack=1. A req still high in the IDLE cycle after DONE is treated as a new request.
- Mid-transaction rules:
  - Changes to bound and no_repeat are ignored; the latched values are used.
  - Dropping req mid-transaction does not abort it; ack still pulses.
- Reset mid-transaction: no ack is produced; history is cleared.
- After MAX_RETRY retries the repeated value is delivered anyway. This guarantees termination.
- Only one transaction is in flight at a time. Other requesters wait and have no timeout.

Decomposition:
- Package rand_req_pkg holds:
  - the state encoding (IDLE=0, SAMPLE=1, REDUCE=2, CHECK=3, DONE=4; 3 bits);
  - the default N_REQ, DATA_W and MAX_RETRY constants.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req and pointer.
  - Outputs: grant index and any_req.
  - The pointer register stays in the parent.

Test Plan:
- Basic raw value: rand_in driven directly by the bench, held at 15; req[0]=1, bound0=0 → ack[0] high exactly 4 cycles after req, rand_out=15, busy low afterwards.
- Multi-step reduction: req[1]=1, bound1=6, rand_in=20 → three subtractions, ack[1] at cycle 7, rand_out=2.
- Round robin: req[0] and req[2] held high continuously, bound=0 → acks ordered 0, 2, 0, 2. A third requester req[3] raised later is granted after 2, before 0.
- No repeat:
  - Setup: req[3], no_repeat=1, bound=24. First request with rand_in=5 → rand_out=5.
  - Second request: hold rand_in=5 for the first two samples, then 9 → rand_out=9 after 2 retries.
  - Third request with rand_in held at 9 → rand_out=9 after exactly 3 retries, ack at cycle 13.
- Bound greater than value: bound=24, rand_in=23 → zero subtractions, rand_out=23, ack at cycle 4.
- Reset mid-operation:
  - Assert reset during REDUCE (bound=1, rand_in=200) → ack=0, busy=0, rand_out=0 immediately.
  - After release, req[0] with no_repeat=1 and rand_in equal to the pre-reset last value → no retry, because history was cleared.

Source files
------------

// File: rtl/rand_req_pkg.sv
// Shared constants and state encoding for the random-value request arbiter.
package rand_req_pkg;

   localparam int N_REQ_DEF     = 4;
   localparam int DATA_W_DEF    = 8;
   localparam int MAX_RETRY_DEF = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SAMPLE = 3'd1,
      ST_REDUCE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/rand_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping at N_REQ. The pointer register lives in the parent.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] grant_o,
   output logic             any_o
);

   logic [IDX_W-1:0] idx;

   // Scan from farthest to nearest so the nearest set bit wins.
   always_comb begin
      grant_o = '0;
      any_o   = 1'b0;
      idx     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = IDX_W'((int'(ptr_i) + k) % N_REQ);
         if (req_i[idx]) begin
            grant_o = idx;
            any_o   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rand_req_arbiter.sv
// Shares one free-running random source among several requesters: grants
// round-robin, samples, reduces modulo the requester's bound by repeated
// subtraction, optionally resamples to avoid repeating the previous value,
// and returns the result with a one-cycle ack.
module rand_req_arbiter
   import rand_req_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_RETRY = MAX_RETRY_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_W-1:0]       rand_in,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] bound,
   input  logic [N_REQ-1:0]        no_repeat,
   output logic [N_REQ-1:0]        ack,
   output logic [DATA_W-1:0]       rand_out,
   output logic                    busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   state_t                         state_q;
   logic [IDX_W-1:0]               ptr_q, ptr_d, g_q;
   logic [DATA_W-1:0]              bound_q, work_q, rand_out_q;
   logic                           nrep_q, busy_q;
   logic [RTY_W-1:0]               retry_q;
   logic [N_REQ-1:0]               ack_q, last_valid_q;
   logic [N_REQ-1:0][DATA_W-1:0]   last_val_q;

   logic [IDX_W-1:0]               pick_idx;
   logic                           pick_any;
   logic                           reduce_done, repeat_hit;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .grant_o (pick_idx),
      .any_o   (pick_any)
   );

   // Next pointer sits just past the winner; explicit wrap keeps
   // non-power-of-two requester counts in range.
   always_comb begin
      ptr_d = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
   end

   assign reduce_done = (bound_q == '0) || (work_q < bound_q);
   // Retry cap bounds the loop so a stuck source still completes.
   assign repeat_hit  = nrep_q && last_valid_q[g_q] &&
                        (work_q == last_val_q[g_q]) &&
                        (retry_q < RTY_W'(MAX_RETRY));

   // Transaction FSM with registered ack/result/busy and per-requester history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         g_q          <= '0;
         bound_q      <= '0;
         nrep_q       <= 1'b0;
         work_q       <= '0;
         retry_q      <= '0;
         ack_q        <= '0;
         rand_out_q   <= '0;
         busy_q       <= 1'b0;
         last_val_q   <= '0;
         last_valid_q <= '0;
      end else begin
         ack_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  g_q     <= pick_idx;
                  bound_q <= bound[int'(pick_idx)*DATA_W +: DATA_W];
                  nrep_q  <= no_repeat[pick_idx];
                  retry_q <= '0;
                  busy_q  <= 1'b1;
                  ptr_q   <= ptr_d;
                  state_q <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               work_q  <= rand_in;
               state_q <= ST_REDUCE;
            end
            ST_REDUCE: begin
               if (reduce_done) state_q <= ST_CHECK;
               else             work_q  <= work_q - bound_q;
            end
            ST_CHECK: begin
               if (repeat_hit) begin
                  retry_q <= retry_q + RTY_W'(1);
                  state_q <= ST_SAMPLE;
               end else begin
                  ack_q[g_q] <= 1'b1;
                  rand_out_q <= work_q;
                  state_q    <= ST_DONE;
               end
            end
            ST_DONE: begin
               last_val_q[g_q]   <= work_q;
               last_valid_q[g_q] <= 1'b1;
               busy_q            <= 1'b0;
               state_q           <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ack      = ack_q;
   assign rand_out = rand_out_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_rand_req_arbiter.sv
// Directed bench for rand_req_arbiter with hand-computed expectations.
module tb_rand_req_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [DW-1:0]     rand_in;
   logic [NR-1:0]     req, no_repeat, ack;
   logic [NR*DW-1:0]  bound;
   logic [DW-1:0]     rand_out;
   logic              busy;

   int checks   = 0;
   int failures = 0;
   int n;
   int exp_seq [6] = '{0, 2, 0, 2, 3, 0};

   always #5 clk = ~clk;

   rand_req_arbiter #(
      .N_REQ     (NR),
      .DATA_W    (DW),
      .MAX_RETRY (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rand_in   (rand_in),
      .req       (req),
      .bound     (bound),
      .no_repeat (no_repeat),
      .ack       (ack),
      .rand_out  (rand_out),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_bound(input int i, input logic [DW-1:0] v);
      bound[i*DW +: DW] = v;
   endtask

   // Raise req[idx] in an idle cycle, wait for ack, check latency/result,
   // drop req on the ack cycle and confirm the block goes idle.
   task automatic run_req(input string tag, input int idx, input int exp_lat,
                          input logic [DW-1:0] exp_val, input int swap_at,
                          input logic [DW-1:0] swap_val);
      int cnt = 0;
      req[idx] = 1'b1;
      while (cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
         if (cnt == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
         if (swap_at != 0 && cnt == swap_at) rand_in = swap_val;
         if (ack != '0) break;
      end
      chk({tag, "_lat"}, cnt, exp_lat);
      chk({tag, "_ack"}, 32'(ack), 32'(1) << idx);
      chk({tag, "_val"}, 32'(rand_out), 32'(exp_val));
      req[idx] = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_ackoff"}, 32'(ack), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      rand_in   = '0;
      req       = '0;
      bound     = '0;
      no_repeat = '0;
      #12;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_out", 32'(rand_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Raw value, no reduction.
      rand_in = 8'd15;
      run_req("raw", 0, 4, 8'd15, 0, 8'd0);

      // 20 -> 14 -> 8 -> 2 with bound 6.
      set_bound(1, 8'd6);
      rand_in = 8'd20;
      run_req("reduce", 1, 7, 8'd2, 0, 8'd0);

      // Value already below bound.
      set_bound(2, 8'd24);
      rand_in = 8'd23;
      run_req("below", 2, 4, 8'd23, 0, 8'd0);

      // No-repeat on requester 3.
      set_bound(3, 8'd24);
      no_repeat[3] = 1'b1;
      rand_in = 8'd5;
      run_req("nr_first", 3, 4, 8'd5, 0, 8'd0);
      rand_in = 8'd5;
      run_req("nr_two", 3, 10, 8'd9, 6, 8'd9);
      rand_in = 8'd9;
      run_req("nr_cap", 3, 13, 8'd9, 0, 8'd0);

      // Round robin with held requests; req[3] joins later.
      set_bound(0, 8'd0);
      set_bound(2, 8'd0);
      rand_in = 8'd7;
      req = 4'b0101;
      for (int k = 0; k < 6; k++) begin
         n = 0;
         while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack != '0) break;
         end
         chk("rr_ack", 32'(ack), 32'(1) << exp_seq[k]);
         chk("rr_gap", n, (k == 0) ? 4 : 5);
         chk("rr_val", 32'(rand_out), 32'd7);
         if (k == 2) req[3] = 1'b1;
         if (k == 4) req[3] = 1'b0;
      end
      req = '0;
      @(posedge clk); #1;
      chk("rr_idle", 32'(busy), 32'd0);

      // Reset while reducing 200 by 1.
      set_bound(1, 8'd1);
      rand_in = 8'd200;
      req[1] = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_ack", 32'(ack), 32'd0);
      chk("mid_busy0", 32'(busy), 32'd0);
      chk("mid_out", 32'(rand_out), 32'd0);
      req[1] = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Requester 0 last delivered 7; history was cleared so no retry.
      no_repeat[0] = 1'b1;
      rand_in = 8'd7;
      run_req("hist", 0, 4, 8'd7, 0, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
